// File: rtl/scanlines_pkg.sv
// Shared types and constants for the scanline generator.
// Optional soft edge build option: SCANLINES_SOFT_EN.
package scanlines_pkg;

  typedef enum logic [1:0] {
    SL_OFF,
    SL_25,
    SL_50,
    SL_75
  } scanline_type_t;

  typedef enum logic {
    S_VBLANK,
    S_ACTIVE
  } state_t;

  localparam int SCANLINES_LATENCY = 2;

endpackage

// File: rtl/scanline_atten.sv
// Per-channel scanline attenuation, purely combinational.
// SCANLINES_SOFT_EN adds the 12.5 % soft edge input.
module scanline_atten
  import scanlines_pkg::*;
(
  input  logic [7:0]     i_c,
  input  scanline_type_t i_type,
  input  logic           i_dark,
`ifdef SCANLINES_SOFT_EN
  input  logic           i_soft,
`endif
  output logic [7:0]     o_c
);

  always_comb begin
    o_c = i_c;
    if (i_type != SL_OFF) begin
      if (i_dark) begin
        case (i_type)
          SL_25:   o_c = i_c - (i_c >> 2);
          SL_50:   o_c = i_c >> 1;
          SL_75:   o_c = i_c >> 2;
          default: o_c = i_c;
        endcase
      end
`ifdef SCANLINES_SOFT_EN
      else if (i_soft) begin
        o_c = i_c - (i_c >> 3);
      end
`endif
    end
  end

endmodule

// File: rtl/scanlines.sv
// Scanline generator: darkens alternate lines with a fixed 2-cycle delay.
// Build option SCANLINES_SOFT_EN softens the first bright line after a dark one.
module scanlines
  import scanlines_pkg::*;
#(
  parameter int LINE_W = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  scanline_type,
  input  logic        line_2x,
  input  logic        phase,
  input  logic [23:0] din,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  output logic [23:0] dout,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out
);

  logic r_old_hs, r_old_vs, r_old_de;
  logic w_hs_fall, w_vs_fall, w_de_rise;

  scanline_type_t r_type;
  logic           r_l2x, r_phase;

  state_t r_state, w_state_nxt;
  logic [LINE_W-1:0] r_line_idx;
  logic r_seen_de;

  logic w_active, w_sel, w_dark, w_count;

  logic [23:0]    r_s1_pix;
  logic           r_s1_hs, r_s1_vs, r_s1_de;
  logic           r_s1_dark;
  scanline_type_t r_s1_type;

  logic [23:0] r_s2_pix;
  logic        r_s2_hs, r_s2_vs, r_s2_de;
  logic [7:0]  w_r, w_g, w_b;

  assign w_hs_fall = r_old_hs & ~hs_in;
  assign w_vs_fall = r_old_vs & ~vs_in;
  assign w_de_rise = ~r_old_de & de_in;

  // The de-rise pixel already belongs to line 0 of the new frame.
  assign w_active = ~w_vs_fall &
                    ((r_state == S_ACTIVE) | w_de_rise);
  assign w_sel    = r_l2x ? r_line_idx[1] : r_line_idx[0];
  assign w_dark   = w_active & (w_sel ^ r_phase);
  assign w_count  = (r_state == S_ACTIVE) & w_hs_fall &
                    r_seen_de & ~w_vs_fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_old_hs <= 1'b0;
      r_old_vs <= 1'b0;
      r_old_de <= 1'b0;
      r_type   <= SL_OFF;
      r_l2x    <= 1'b0;
      r_phase  <= 1'b0;
    end else begin
      r_old_hs <= hs_in;
      r_old_vs <= vs_in;
      r_old_de <= de_in;
      if (w_vs_fall) begin
        r_type  <= scanline_type_t'(scanline_type);
        r_l2x   <= line_2x;
        r_phase <= phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_VBLANK;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_vs_fall) begin
      w_state_nxt = S_VBLANK;
    end else begin
      unique case (r_state)
        S_VBLANK: if (w_de_rise) w_state_nxt = S_ACTIVE;
        S_ACTIVE: w_state_nxt = S_ACTIVE;
        default:  w_state_nxt = S_VBLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_line_idx <= '0;
      r_seen_de  <= 1'b0;
    end else if (w_vs_fall) begin
      r_line_idx <= '0;
      r_seen_de  <= 1'b0;
    end else if (r_state == S_VBLANK) begin
      if (w_de_rise) begin
        r_line_idx <= '0;
        r_seen_de  <= 1'b1;
      end
    end else if (w_count) begin
      r_line_idx <= r_line_idx + LINE_W'(1);
      r_seen_de  <= 1'b0;
    end else if (de_in) begin
      r_seen_de <= 1'b1;
    end
  end

`ifdef SCANLINES_SOFT_EN
  logic r_prev_dark, r_s1_soft;

  always_ff @(posedge clk) begin
    if (!reset_n)       r_prev_dark <= 1'b0;
    else if (w_vs_fall) r_prev_dark <= 1'b0;
    else if (w_count)   r_prev_dark <= w_dark;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_s1_soft <= 1'b0;
    else          r_s1_soft <= ~w_dark & r_prev_dark;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_pix  <= '0;
      r_s1_hs   <= 1'b0;
      r_s1_vs   <= 1'b0;
      r_s1_de   <= 1'b0;
      r_s1_dark <= 1'b0;
      r_s1_type <= SL_OFF;
      r_s2_pix  <= '0;
      r_s2_hs   <= 1'b0;
      r_s2_vs   <= 1'b0;
      r_s2_de   <= 1'b0;
    end else begin
      r_s1_pix  <= din;
      r_s1_hs   <= hs_in;
      r_s1_vs   <= vs_in;
      r_s1_de   <= de_in;
      r_s1_dark <= w_dark;
      r_s1_type <= r_type;
      r_s2_pix  <= {w_r, w_g, w_b};
      r_s2_hs   <= r_s1_hs;
      r_s2_vs   <= r_s1_vs;
      r_s2_de   <= r_s1_de;
    end
  end

  scanline_atten u_r (
    .i_c    (r_s1_pix[23:16]),
    .i_type (r_s1_type),
    .i_dark (r_s1_dark),
`ifdef SCANLINES_SOFT_EN
    .i_soft (r_s1_soft),
`endif
    .o_c    (w_r)
  );

  scanline_atten u_g (
    .i_c    (r_s1_pix[15:8]),
    .i_type (r_s1_type),
    .i_dark (r_s1_dark),
`ifdef SCANLINES_SOFT_EN
    .i_soft (r_s1_soft),
`endif
    .o_c    (w_g)
  );

  scanline_atten u_b (
    .i_c    (r_s1_pix[7:0]),
    .i_type (r_s1_type),
    .i_dark (r_s1_dark),
`ifdef SCANLINES_SOFT_EN
    .i_soft (r_s1_soft),
`endif
    .o_c    (w_b)
  );

  assign dout   = r_s2_pix;
  assign hs_out = r_s2_hs;
  assign vs_out = r_s2_vs;
  assign de_out = r_s2_de;

endmodule

// File: tb/tb_scanlines.sv
// Directed self-checking bench for the scanline generator.
// Outputs are compared one cycle-step after the pixel that produced them.
module tb_scanlines;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  scanline_type = 2'd0;
  logic        line_2x = 1'b0;
  logic        phase = 1'b0;
  logic [23:0] din = '0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic        de_in = 1'b0;
  logic [23:0] dout;
  logic        hs_out, vs_out, de_out;

  int total = 0;
  int bad = 0;

  logic [23:0] p_exp = '0, o_exp = '0;
  logic p_hs = 0, p_vs = 0, p_de = 0;
  logic o_hs = 0, o_vs = 0, o_de = 0;

  scanlines #(.LINE_W(11)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .scanline_type (scanline_type),
    .line_2x       (line_2x),
    .phase         (phase),
    .din           (din),
    .hs_in         (hs_in),
    .vs_in         (vs_in),
    .de_in         (de_in),
    .dout          (dout),
    .hs_out        (hs_out),
    .vs_out        (vs_out),
    .de_out        (de_out)
  );

  always #5 clk = ~clk;

  // Apply one input cycle; after the edge, o_* hold what the outputs
  // must show (the pixel applied in the previous call, 2 clocks later).
  task automatic cyc(input logic [23:0] d, input logic h, input logic v,
                     input logic e, input logic [23:0] x);
    din = d; hs_in = h; vs_in = v; de_in = e;
    o_exp = p_exp; o_hs = p_hs; o_vs = p_vs; o_de = p_de;
    p_exp = reset_n ? x : 24'h0;
    p_hs = reset_n & h; p_vs = reset_n & v; p_de = reset_n & e;
    @(posedge clk); #1;
  endtask

  task automatic hs_pulse();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic vs_pulse();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(24'hFFFFFF, 0, 0, 1, 24'h0);
      total++;
      if ({dout, hs_out, vs_out, de_out} !== 27'h0) begin
        bad++;
        $display("FAIL reset c=%0d got=%h want=0", i,
                 {dout, hs_out, vs_out, de_out});
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) cyc(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF);
      else       cyc(0, 0, 0, 0, 0);
      total++;
      if ({dout, hs_out, vs_out, de_out} !==
          {o_exp, o_hs, o_vs, o_de}) begin
        bad++;
        $display("FAIL release c=%0d got=%h want=%h", i,
                 {dout, hs_out, vs_out, de_out},
                 {o_exp, o_hs, o_vs, o_de});
      end
    end
    if (o_exp !== 24'hFFFFFF) begin
      total++; bad++;
      $display("FAIL release_model got=%h want=ffffff", o_exp);
    end
  endtask

  task automatic test_type50();
    scanline_type = 2'd2; line_2x = 0; phase = 0;
    vs_pulse();
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 5; p++) begin
        if (p < 4)
          cyc(24'h804020, 0, 0, 1,
              l[0] ? 24'h402010 : 24'h804020);
        else
          cyc(0, 0, 0, 0, 0);
        total++;
        if ({dout, hs_out, vs_out, de_out} !==
            {o_exp, o_hs, o_vs, o_de}) begin
          bad++;
          $display("FAIL type50 l=%0d p=%0d got=%h want=%h", l, p,
                   {dout, hs_out, vs_out, de_out},
                   {o_exp, o_hs, o_vs, o_de});
        end
      end
      hs_pulse();
    end
  endtask

  task automatic test_type75_2x();
    scanline_type = 2'd3; line_2x = 1; phase = 0;
    vs_pulse();
    for (int l = 0; l < 5; l++) begin
      for (int p = 0; p < 5; p++) begin
        if (p < 4)
          cyc(24'hFFFFFF, 0, 0, 1,
              l[1] ? 24'h3F3F3F : 24'hFFFFFF);
        else
          cyc(0, 0, 0, 0, 0);
        total++;
        if ({dout, hs_out, vs_out, de_out} !==
            {o_exp, o_hs, o_vs, o_de}) begin
          bad++;
          $display("FAIL type75_2x l=%0d p=%0d got=%h want=%h", l, p,
                   {dout, hs_out, vs_out, de_out},
                   {o_exp, o_hs, o_vs, o_de});
        end
      end
      hs_pulse();
    end
  endtask

  task automatic test_type_change();
    logic [23:0] ex [4];
    logic [23:0] px;
    ex[0] = 24'h804020; ex[1] = 24'h603018;
    scanline_type = 2'd1; line_2x = 0; phase = 0;
    vs_pulse();
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 2; l++) begin
        if (l == 1) scanline_type = 2'd0;
        for (int p = 0; p < 5; p++) begin
          px = (f == 0) ? 24'h804020 : 24'h123456 + 24'(p * 24'h010203);
          if (p == 4)      cyc(0, 0, 0, 0, 0);
          else if (f == 0) cyc(px, 0, 0, 1, ex[l]);
          else             cyc(px, 0, 0, 1, px);
          total++;
          if ({dout, hs_out, vs_out, de_out} !==
              {o_exp, o_hs, o_vs, o_de}) begin
            bad++;
            $display("FAIL type_change f=%0d l=%0d p=%0d got=%h want=%h",
                     f, l, p, {dout, hs_out, vs_out, de_out},
                     {o_exp, o_hs, o_vs, o_de});
          end
        end
        hs_pulse();
      end
      vs_pulse();
    end
  endtask

  task automatic test_vs_hs_same();
    logic [23:0] e;
    scanline_type = 2'd2; line_2x = 0;
    for (int ph = 0; ph < 2; ph++) begin
      phase = ph[0];
      vs_pulse();
      for (int l = 0; l < 4; l++) begin
        if (l == 2) begin
          cyc(0, 1, 1, 0, 0);
          cyc(0, 1, 1, 0, 0);
          cyc(0, 0, 0, 0, 0);
          for (int b = 0; b < 3; b++) hs_pulse();
        end
        e = ((l % 2) ^ ph) != 0 ? 24'h402010 : 24'h804020;
        for (int p = 0; p < 5; p++) begin
          if (p < 4) cyc(24'h804020, 0, 0, 1, e);
          else       cyc(0, 0, 0, 0, 0);
          total++;
          if ({dout, hs_out, vs_out, de_out} !==
              {o_exp, o_hs, o_vs, o_de}) begin
            bad++;
            $display("FAIL vs_hs_same ph=%0d l=%0d p=%0d got=%h want=%h",
                     ph, l, p, {dout, hs_out, vs_out, de_out},
                     {o_exp, o_hs, o_vs, o_de});
          end
        end
        hs_pulse();
      end
    end
  endtask

  task automatic test_soft();
    logic [23:0] ex [4];
    ex[0] = 24'h808080; ex[1] = 24'h606060;
`ifdef SCANLINES_SOFT_EN
    ex[2] = 24'h707070;
`else
    ex[2] = 24'h808080;
`endif
    ex[3] = 24'h606060;
    scanline_type = 2'd1; line_2x = 0; phase = 0;
    vs_pulse();
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 5; p++) begin
        if (p < 4) cyc(24'h808080, 0, 0, 1, ex[l]);
        else       cyc(0, 0, 0, 0, 0);
        total++;
        if ({dout, hs_out, vs_out, de_out} !==
            {o_exp, o_hs, o_vs, o_de}) begin
          bad++;
          $display("FAIL soft l=%0d p=%0d got=%h want=%h", l, p,
                   {dout, hs_out, vs_out, de_out},
                   {o_exp, o_hs, o_vs, o_de});
        end
      end
      hs_pulse();
    end
  endtask

  initial begin
    test_reset();
    test_type50();
    test_type75_2x();
    test_type_change();
    test_vs_hs_same();
    test_soft();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
